// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, fetch
// sequencer state encoding, prefetch entry layout and PC helpers.
package if_fetch_unit_pkg;

  // All-zero word presented to IF/ID when no real instruction is available.
  localparam logic [31:0] INST_NOP = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] PC_STEP = 32'h0000_0004;

  // Fetch sequencer states (2-bit encoding shared with the decode side).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // One prefetch entry: the PC the word was fetched from and the word itself.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential PC; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  // Saturating increment used by the observation counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'h0000_0001;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction memory request/response channel used by the fetch stage.
// The fetch unit is the master (drives req/addr); memory is the slave.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Prefetch FIFO for the fetch stage: DEPTH entries of {pc, inst}.
// Flush has priority over push and pop; pop on an empty FIFO is ignored.
module if_fetch_unit_fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Qualify requests: no pop from empty, no push into full unless a pop frees a slot.
  always_comb begin
    empty   = (count == '0);
    full    = (count == FULL_COUNT);
    do_pop  = pop && !empty && !flush;
    do_push = push && !flush && (!full || do_pop);
  end

  // Head entry, all-zero when nothing is stored.
  always_comb begin
    if (empty) begin
      rdata = '0;
    end else begin
      rdata = mem[rd_ptr];
    end
  end

  // Entry storage; payload needs no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; a flush empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage feeding the IF/ID register.
// Owns the fetch PC, keeps at most one request outstanding to a
// variable-latency instruction memory, buffers returned words in a small
// prefetch FIFO and presents {pc, inst} (or an all-zero bubble) to IF/ID.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating bubble/drop counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hazard_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_target_i,
  if_fetch_unit_if.master     imem,
  output logic [31:0]         pc_o,
  output logic [31:0]         inst_o,
  output logic                valid_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_bubble_o,
  output logic [31:0]         perf_drop_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   addr;
  logic          req;

  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic [CW-1:0] count;
  logic          empty;
  logic          push;
  logic          pop;
  logic [CW-1:0] post_count;
  logic          room_after_push;

  assign imem.req  = req;
  assign imem.addr = addr;

  // Present the FIFO head to IF/ID, or a zero bubble when nothing is buffered.
  always_comb begin
    valid_o = !empty;
    if (empty) begin
      pc_o   = 32'h0000_0000;
      inst_o = INST_NOP;
    end else begin
      pc_o   = head.pc;
      inst_o = head.inst;
    end
  end

  // FIFO control: consume when IF/ID takes the head, fill from a kept response.
  always_comb begin
    pop             = !empty && !hazard_i && !branch_i;
    push            = (state == S_WAIT) && imem.rvalid && !branch_i;
    push_entry.pc   = req_pc;
    push_entry.inst = imem.rdata;
    if (pop) begin
      post_count = count;
    end else begin
      post_count = count + CNT_ONE;
    end
    room_after_push = (post_count < DEPTH_C);
  end

  if_fetch_unit_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (branch_i),
    .wdata (push_entry),
    .rdata (head),
    .count (count),
    .empty (empty)
  );

  // Fetch sequencer: PC, request address/valid and the outstanding transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      addr     <= RESET_PC;
      req      <= 1'b0;
    end else begin
      // A redirect always retargets the fetch PC; the REQ grant case below
      // overrides this only when no branch is present.
      if (branch_i) begin
        fetch_pc <= branch_target_i;
      end
      case (state)
        S_IDLE: begin
          if (branch_i) begin
            state <= S_REQ;
            req   <= 1'b1;
            addr  <= branch_target_i;
          end else if (count < DEPTH_C) begin
            state <= S_REQ;
            req   <= 1'b1;
            addr  <= fetch_pc;
          end else begin
            state <= S_IDLE;
            req   <= 1'b0;
          end
        end
        S_REQ: begin
          if (imem.gnt && !branch_i) begin
            state    <= S_WAIT;
            req      <= 1'b0;
            req_pc   <= addr;
            fetch_pc <= next_pc(addr);
          end else if (imem.gnt) begin
            // Granted but already stale: its response must be swallowed.
            state <= S_DROP;
            req   <= 1'b0;
          end else if (branch_i) begin
            // Not yet granted, so the request can simply be retargeted.
            state <= S_REQ;
            req   <= 1'b1;
            addr  <= branch_target_i;
          end else begin
            state <= S_REQ;
            req   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.rvalid && !branch_i) begin
            if (room_after_push) begin
              state <= S_REQ;
              req   <= 1'b1;
              addr  <= fetch_pc;
            end else begin
              state <= S_IDLE;
              req   <= 1'b0;
            end
          end else if (imem.rvalid) begin
            state <= S_IDLE;
            req   <= 1'b0;
          end else if (branch_i) begin
            state <= S_DROP;
            req   <= 1'b0;
          end else begin
            state <= S_WAIT;
            req   <= 1'b0;
          end
        end
        S_DROP: begin
          if (imem.rvalid) begin
            state <= S_IDLE;
          end else begin
            state <= S_DROP;
          end
          req <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        discard;
  logic [31:0] bubble_cnt;
  logic [31:0] drop_cnt;

  // A response is thrown away when it belongs to a squashed fetch.
  always_comb begin
    discard = imem.rvalid &&
              ((state == S_DROP) || ((state == S_WAIT) && branch_i));
  end

  // Saturating observation counters for bubbles and discarded responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt <= 32'h0000_0000;
      drop_cnt   <= 32'h0000_0000;
    end else begin
      if (!valid_o && !hazard_i) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
      if (discard) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign perf_bubble_o = bubble_cnt;
  assign perf_drop_o   = drop_cnt;
`endif

endmodule
